onehot_rr_arbiter: RTL and testbench

Round-robin arbiter that produces the registered one-hot select driving the one-hot `mux` downstream of it. It chooses one of SELECT_WIDTH requesters, holds that grant stable for a whole multi-beat transfer, and releases it on the final accepted beat. It then rotates priority so every requester is served fairly. Its `gnt` output connects directly to the mux `sel` port, so the mux never sees a zero-hot or multi-hot select while a transfer is in flight.

---
 rtl/onehot_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_rr_arbiter
//
// Round-robin arbiter that produces the registered one-hot select for a
// downstream one-hot mux. A grant is held for a whole multi-beat transfer. It
// is released on the final accepted beat (ready && last), or when the granted
// requester drops its request. After a release, priority rotates to the
// requester just after the one that was served. There is always one idle
// cycle between grants, so the mux select never changes from one requester
// straight to another.
//
// Parameters:
//   SELECT_WIDTH  number of requesters (>= 1)
//   IDX_W         width of the binary grant index (min 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester request level
//   ready      downstream accepts the current beat
//   last       current beat is the final beat (only meaningful with ready)
//   gnt        registered one-hot grant, drives mux sel
//   gnt_valid  a grant is active
//   gnt_idx    binary index of the granted requester
// -----------------------------------------------------------------------------
module onehot_rr_arbiter #(
    parameter int SELECT_WIDTH = 4,
    parameter int IDX_W        = (SELECT_WIDTH > 1) ? $clog2(SELECT_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SELECT_WIDTH-1:0] req,
    input  logic                    ready,
    input  logic                    last,
    output logic [SELECT_WIDTH-1:0] gnt,
    output logic                    gnt_valid,
    output logic [IDX_W-1:0]        gnt_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                  state_q;
    logic [SELECT_WIDTH-1:0] gnt_q;
    logic                    gnt_valid_q;
    logic [IDX_W-1:0]        gnt_idx_q;
    logic [IDX_W-1:0]        ptr_q;

    logic [SELECT_WIDTH-1:0] pick_onehot_d;
    logic [IDX_W-1:0]        pick_idx_d;
    logic                    pick_found_d;
    logic [IDX_W-1:0]        ptr_d;
    logic                    release_d;

    // Rotating priority pick: first scan the bits at or above ptr, then wrap
    // and scan from bit 0. The first hit wins, so the search order is
    // ptr, ptr+1, ..., W-1, 0, ..., ptr-1.
    // NOTE: every output of this block gets a default before the loops, so
    // no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        pick_onehot_d = '0;
        pick_idx_d    = '0;
        pick_found_d  = 1'b0;
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (!pick_found_d && (i >= int'(ptr_q)) && req[i]) begin
                pick_found_d     = 1'b1;
                pick_onehot_d[i] = 1'b1;
                pick_idx_d       = IDX_W'(i);
            end
        end
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (!pick_found_d && req[i]) begin
                pick_found_d     = 1'b1;
                pick_onehot_d[i] = 1'b1;
                pick_idx_d       = IDX_W'(i);
            end
        end
    end

    // Explicit modulo so that non-power-of-two widths wrap correctly.
    always_comb begin
        if (int'(gnt_idx_q) == SELECT_WIDTH - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_q + IDX_W'(1);
        end
    end

    // Release on the final accepted beat. An abort (the granted requester
    // drops its request) releases the same way, so the case where both happen
    // together needs no special handling.
    assign release_d = (ready && last) || !(|(req & gnt_q));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q     <= GRANT;
                        gnt_q       <= pick_onehot_d;
                        gnt_valid_q <= 1'b1;
                        gnt_idx_q   <= pick_idx_d;
                    end
                end
                GRANT: begin
                    // gnt_idx_q holds its value while idle; it only has to
                    // be correct while gnt_valid is high.
                    if (release_d) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onehot_rr_arbiter
//
// Directed testbench for onehot_rr_arbiter with SELECT_WIDTH = 4. Inputs are
// driven 1 ns after a rising edge, and outputs are sampled at the same point
// after the next edge. Expected values are written by hand in the stimulus
// sequence.
// -----------------------------------------------------------------------------
module tb_onehot_rr_arbiter;

    localparam int W     = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst;
    logic [W-1:0]     req;
    logic             ready;
    logic             last;
    logic [W-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    int checks   = 0;
    int failures = 0;

    onehot_rr_arbiter #(
        .SELECT_WIDTH(W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .last     (last),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares the grant vector and gnt_valid. The index is compared only
    // while a grant is expected.
    task automatic chk_out(input string tag, input logic [W-1:0] exp_gnt,
                           input logic exp_valid, input logic [IDX_W-1:0] exp_idx);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(exp_valid));
        if (exp_valid) check({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0]     rot_gnt [4];
        logic [IDX_W-1:0] rot_idx [4];
        logic             burst_rdy [6];
        logic             burst_lst [6];

        rot_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
        burst_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        burst_lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // ---- Reset values: rst held with all requests asserted ------------
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b0;
        last  = 1'b0;
        step();
        step();
        chk_out("reset", 4'b0000, 1'b0, 2'd0);
        check("reset_idx", 32'(gnt_idx), 32'd0);

        rst = 1'b0;
        step();
        chk_out("first_grant", 4'b0001, 1'b1, 2'd0);

        // ---- Rotation: single-beat transfers, req = 1111 held -------------
        for (int k = 0; k < 4; k++) begin
            ready = 1'b1;
            last  = 1'b1;
            step();
            chk_out($sformatf("rot%0d_gap", k), 4'b0000, 1'b0, 2'd0);
            ready = 1'b0;
            last  = 1'b0;
            step();
            chk_out($sformatf("rot%0d", k), rot_gnt[k], 1'b1, rot_idx[k]);
        end

        // Release index 0, so ptr = 1. Then only requester 2 asks.
        ready = 1'b1;
        last  = 1'b1;
        step();
        chk_out("pre_burst_gap", 4'b0000, 1'b0, 2'd0);
        ready = 1'b0;
        last  = 1'b0;
        req   = 4'b0100;
        step();
        chk_out("burst_grant", 4'b0100, 1'b1, 2'd2);

        // ---- Hold during burst, including last without ready ---------------
        // Other requesters are also raised, and they must be ignored.
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            ready = burst_rdy[k];
            last  = burst_lst[k];
            step();
            if (k < 5) chk_out($sformatf("burst%0d", k), 4'b0100, 1'b1, 2'd2);
            else       chk_out("burst_release", 4'b0000, 1'b0, 2'd0);
        end

        // ---- Skip and wrap: ptr = 3, req = 0011 -> requester 0 -------------
        ready = 1'b0;
        last  = 1'b0;
        req   = 4'b0011;
        step();
        chk_out("wrap", 4'b0001, 1'b1, 2'd0);
        ready = 1'b1;
        last  = 1'b1;
        step();
        chk_out("wrap_release", 4'b0000, 1'b0, 2'd0);
        ready = 1'b0;
        last  = 1'b0;
        req   = 4'b0010;
        step();
        chk_out("skip", 4'b0010, 1'b1, 2'd1);

        // ---- Abort: drop req[1] with ready = 0 -> ptr = 2 --------------------
        req = 4'b0000;
        step();
        chk_out("abort", 4'b0000, 1'b0, 2'd0);
        req = 4'b1111;
        step();
        chk_out("after_abort", 4'b0100, 1'b1, 2'd2);

        // Release index 2, then grant index 3.
        ready = 1'b1;
        last  = 1'b1;
        step();
        chk_out("pre_rst_gap", 4'b0000, 1'b0, 2'd0);
        ready = 1'b0;
        last  = 1'b0;
        step();
        chk_out("grant3", 4'b1000, 1'b1, 2'd3);

        // ---- Async reset mid-grant, between clock edges ----------------------
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0, 2'd0);
        check("async_rst_idx", 32'(gnt_idx), 32'd0);
        step();
        rst = 1'b0;
        req = 4'b1000;
        #1;
        chk_out("rst_deassert", 4'b0000, 1'b0, 2'd0);
        step();
        chk_out("post_rst_grant", 4'b1000, 1'b1, 2'd3);

        // ---- Abort and release together: one ordinary release, ptr = 0 -----
        req   = 4'b0000;
        ready = 1'b1;
        last  = 1'b1;
        step();
        chk_out("both_release", 4'b0000, 1'b0, 2'd0);
        ready = 1'b0;
        last  = 1'b0;
        req   = 4'b1111;
        step();
        chk_out("after_both", 4'b0001, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
